// File: rtl/uart_rx.sv
// 8x-oversampled UART receiver: start, DATA_BITS data bits LSB first, one stop bit.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of ticks 1..3.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rxs low
// S_START | validating the start bit at mid-bit
// S_DATA  | shifting in data bits at mid-bit
// S_STOP  | checking the stop bit, then publishing or flagging
module uart_rx #(
    parameter int DATA_BITS = 7,
    parameter int OVS       = 8
) (
    input  logic                 clk8x,
    input  logic                 rst_n,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Dvalid,
    output logic                 FrameErr
);

    localparam int TICK_W = $clog2(OVS);
    localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(OVS / 2 - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [TICK_W-1:0]      r_tick, w_tick_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0]   r_dout, w_dout_nxt;
    logic                   r_dvalid, w_dvalid_nxt;
    logic                   r_ferr, w_ferr_nxt;
    logic                   r_sync1, r_sync2;
    logic                   w_mid;
    logic                   w_sample;

    always_ff @(posedge clk8x or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

    assign w_mid = (r_tick == SAMPLE_TICK);

`ifdef UART_RX_MAJORITY_EN
    logic r_maj1, r_maj2;

    // The two early votes are captured one and two ticks before the sample point.
    always_ff @(posedge clk8x or negedge rst_n) begin
        if (!rst_n) begin
            r_maj1 <= 1'b1;
            r_maj2 <= 1'b1;
        end else begin
            if (r_tick == SAMPLE_TICK - TICK_W'(2)) r_maj1 <= r_sync2;
            if (r_tick == SAMPLE_TICK - TICK_W'(1)) r_maj2 <= r_sync2;
        end
    end

    assign w_sample = (r_maj1 & r_maj2) | (r_maj1 & r_sync2) | (r_maj2 & r_sync2);
`else
    assign w_sample = r_sync2;
`endif

    always_ff @(posedge clk8x or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_dout   <= w_dout_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick + TICK_W'(1);
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_dout_nxt   = r_dout;
        w_dvalid_nxt = 1'b0;
        w_ferr_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                w_idx_nxt  = '0;
                if (!r_sync2) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_mid) begin
                    if (w_sample) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift_nxt = {w_sample, r_shift[DATA_BITS-1:1]};
                    if (r_idx == LAST_IDX) w_state_nxt = S_STOP;
                    else                   w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            S_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (w_mid) begin
                    if (w_sample) begin
                        w_dout_nxt   = r_shift;
                        w_dvalid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt   = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Dout     = r_dout;
    assign Dvalid   = r_dvalid;
    assign FrameErr = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially at 8 clk8x per bit,
// expected events are queued at drive time and matched against observed Dvalid/FrameErr pulses.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DB = 7;

    logic          clk8x = 1'b0;
    logic          rst_n = 1'b0;
    logic          RxD   = 1'b1;
    logic [DB-1:0] Dout;
    logic          Dvalid;
    logic          FrameErr;

    uart_rx #(.DATA_BITS(DB), .OVS(8)) dut (
        .clk8x    (clk8x),
        .rst_n    (rst_n),
        .RxD      (RxD),
        .Dout     (Dout),
        .Dvalid   (Dvalid),
        .FrameErr (FrameErr)
    );

    always #6510.417 clk8x = ~clk8x;

    typedef struct {
        bit            ferr;
        logic [DB-1:0] data;
        int            t0;
    } ev_t;

    ev_t           exp_q[$];
    ev_t           obs_q[$];
    ev_t           mon_e;
    int            checks   = 0;
    int            errors   = 0;
    int            cyc      = 0;
    int            both_cnt = 0;
    logic [DB-1:0] last_dout = '0;

    always @(posedge clk8x) cyc <= cyc + 1;

    always @(negedge clk8x) begin
        if (Dvalid && FrameErr) both_cnt++;
        if (Dvalid || FrameErr) begin
            mon_e.ferr = FrameErr;
            mon_e.data = Dout;
            mon_e.t0   = cyc;
            obs_q.push_back(mon_e);
        end
    end

    task automatic drive_bit(input logic v, input bit glitch);
        for (int i = 0; i < 8; i++) begin
            RxD = (glitch && i == 4) ? ~v : v;
            @(negedge clk8x);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input int gbit,
                              output int t0);
        t0 = cyc;
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < DB; k++) drive_bit(d[k], k == gbit);
        drive_bit(stop_v, 1'b0);
        RxD = 1'b1;
    endtask

    task automatic push_valid(input logic [DB-1:0] d, input int t0);
        ev_t e;
        e.ferr = 1'b0; e.data = d; e.t0 = t0;
        exp_q.push_back(e);
        last_dout = d;
    endtask

    task automatic push_ferr(input int t0);
        ev_t e;
        e.ferr = 1'b1; e.data = last_dout; e.t0 = t0;
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk8x);
        end
        repeat (24) @(negedge clk8x);
    endtask

    task automatic test_reset();
        int t0; bit ok; ev_t e, o;
        rst_n = 1'b0;
        RxD   = 1'b0;
        repeat (4) @(negedge clk8x);
        checks++;
        if (Dout !== '0 || Dvalid !== 1'b0 || FrameErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: Dout=%h Dvalid=%b FrameErr=%b, required 0/0/0", Dout, Dvalid, FrameErr);
        end
        rst_n = 1'b1;
        send_frame(7'h33, 1'b1, -1, t0);
        push_valid(7'h33, t0);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_low_line_timeout: no output within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reset_low_line_missing: expected data %h not seen", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== e.ferr || o.data !== e.data) begin
                    errors++;
                    $display("FAIL reset_low_line: got ferr=%b data=%h, required ferr=%b data=%h", o.ferr, o.data, e.ferr, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reset_low_line_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_basic();
        int t0; bit ok; ev_t e, o;
        send_frame(7'h55, 1'b1, -1, t0);
        push_valid(7'h55, t0);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: no Dvalid within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL basic_missing: expected %h not seen", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== 1'b0 || o.data !== e.data) begin
                    errors++;
                    $display("FAIL basic_data: got ferr=%b Dout=%h, required ferr=0 Dout=%h", o.ferr, o.data, e.data);
                end
                checks++;
                if (o.t0 - e.t0 < 70 || o.t0 - e.t0 > 72) begin
                    errors++;
                    $display("FAIL basic_latency: got %0d cycles to sample, required 70..72", o.t0 - e.t0);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_false_start();
        RxD = 1'b0;
        repeat (2) @(negedge clk8x);
        RxD = 1'b1;
        repeat (60) @(negedge clk8x);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL false_start_events: got %0d events, required 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (Dout !== last_dout) begin
            errors++; $display("FAIL false_start_dout: got %h, required %h", Dout, last_dout);
        end
    endtask

    task automatic test_frame_err();
        int t0; bit ok; ev_t e, o;
        send_frame(7'h2A, 1'b0, -1, t0);
        push_ferr(t0);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_err_timeout: no FrameErr within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL frame_err_missing: FrameErr not seen");
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== 1'b1 || o.data !== e.data) begin
                    errors++;
                    $display("FAIL frame_err: got ferr=%b Dout=%h, required ferr=1 Dout=%h", o.ferr, o.data, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL frame_err_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
        checks++;
        if (Dout !== last_dout) begin errors++; $display("FAIL frame_err_dout: got %h, required %h", Dout, last_dout); end
    endtask

    task automatic test_back_to_back();
        int t0, t1; bit ok; ev_t e, o;
        send_frame(7'h7F, 1'b1, -1, t0);
        push_valid(7'h7F, t0);
        send_frame(7'h00, 1'b1, -1, t1);
        push_valid(7'h00, t1);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d events, required 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_missing: expected %h not seen", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== 1'b0 || o.data !== e.data || o.t0 - e.t0 < 70 || o.t0 - e.t0 > 72) begin
                    errors++;
                    $display("FAIL b2b_data: got ferr=%b Dout=%h lat=%0d, required ferr=0 Dout=%h lat=70..72", o.ferr, o.data, o.t0 - e.t0, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_midframe();
        int t0; bit ok; ev_t e, o;
        logic [DB-1:0] d;
        d = 7'h6B;
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(d[k], 1'b0);
        RxD = d[3];
        repeat (3) @(negedge clk8x);
        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (2) @(negedge clk8x);
        checks++;
        if (Dout !== '0 || Dvalid !== 1'b0 || FrameErr !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset_values: Dout=%h Dvalid=%b FrameErr=%b, required 0/0/0", Dout, Dvalid, FrameErr);
        end
        last_dout = '0;
        rst_n = 1'b1;
        repeat (80) @(negedge clk8x);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL midframe_aborted: got %0d events, required 0", obs_q.size()); obs_q.delete();
        end
        send_frame(7'h11, 1'b1, -1, t0);
        push_valid(7'h11, t0);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midframe_timeout: no Dvalid within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL midframe_missing: expected %h not seen", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== 1'b0 || o.data !== e.data) begin
                    errors++;
                    $display("FAIL midframe_data: got ferr=%b Dout=%h, required ferr=0 Dout=%h", o.ferr, o.data, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midframe_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_majority();
        int t0; bit ok; ev_t e, o;
        logic [DB-1:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 7'h55;
`else
        want = 7'h51;
`endif
        send_frame(7'h55, 1'b1, 2, t0);
        push_valid(want, t0);
        wait_obs(exp_q.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL glitch_timeout: no Dvalid within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL glitch_missing: expected %h not seen", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.ferr !== 1'b0 || o.data !== e.data) begin
                    errors++;
                    $display("FAIL glitch_data: got ferr=%b Dout=%h, required ferr=0 Dout=%h", o.ferr, o.data, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_extra: %0d extra events", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        @(negedge clk8x);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_basic();
        test_back_to_back();
        test_reset_midframe();
        test_majority();
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL exclusive_pulses: Dvalid and FrameErr together %0d times, required 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
